// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings and the read-slave FSM state type.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } axi_rd_state_e;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  axi_burst_e        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] size_bytes;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;

  always_comb begin
    size_bytes = ADDR_W'(1) << size;
    size_mask  = size_bytes - ADDR_W'(1);
    wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    // Aligning before the add makes an unaligned INCR start snap to the size grid.
    incr_addr  = (addr & ~size_mask) + size_bytes;
    next_addr  = addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI read-only slave serving bursts from an internal register array with a backdoor write port.
module axi_read_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ID_W-1:0]              arid,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_W-1:0]              rid,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]            mem_wdata
);

  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam int IDX_W      = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  axi_rd_state_e     state;
  axi_burst_e        ar_burst;
  axi_burst_e        burst_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] launch_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [2:0]        size_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [7:0]        launch_beat;
  logic              slverr_q;
  logic              ar_slverr;
  logic              launch_slverr;
  logic              launch_decerr;
  logic              launch_last;
  logic [DATA_W-1:0] launch_data;
  axi_resp_e         launch_resp;
  logic              ar_fire;
  logic              r_fire;

  assign ar_burst = axi_burst_e'(arburst);
  assign ar_fire  = arvalid && arready;
  assign r_fire   = rvalid && rready;

  always_comb begin
    ar_slverr = (arsize > 3'(BYTE_SHIFT)) || (ar_burst == BURST_RSVD) ||
                ((ar_burst == BURST_WRAP) &&
                 (!wrap_len_ok(arlen) ||
                  ((araddr & ((ADDR_W'(1) << arsize) - ADDR_W'(1))) != '0)));
  end

  axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (cur_addr),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Beat 0 is launched straight from the AR inputs; later beats from the address generator.
  always_comb begin
    if (state == ST_IDLE) begin
      launch_addr   = araddr;
      launch_slverr = ar_slverr;
      launch_beat   = '0;
      launch_last   = (arlen == '0);
    end else begin
      launch_addr   = next_addr;
      launch_slverr = slverr_q;
      launch_beat   = beat_q + 8'd1;
      launch_last   = ((beat_q + 8'd1) == len_q);
    end
    word_addr     = launch_addr >> BYTE_SHIFT;
    launch_decerr = (word_addr >= ADDR_W'(MEM_WORDS));
    launch_data   = '0;
    launch_resp   = RESP_OKAY;
    if (launch_slverr) begin
      launch_resp = RESP_SLVERR;
    end else if (launch_decerr) begin
      launch_resp = RESP_DECERR;
    end else begin
      launch_data = mem[word_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= '0;
      rid      <= '0;
      rdata    <= '0;
      cur_addr <= '0;
      size_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      burst_q  <= BURST_FIXED;
      slverr_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_fire) begin
            state    <= ST_BURST;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= arid;
            size_q   <= arsize;
            len_q    <= arlen;
            burst_q  <= ar_burst;
            slverr_q <= ar_slverr;
            cur_addr <= launch_addr;
            beat_q   <= launch_beat;
            rdata    <= launch_data;
            rresp    <= launch_resp;
            rlast    <= launch_last;
          end else begin
            arready <= 1'b1;
          end
        end
        ST_BURST: begin
          if (r_fire) begin
            if (rlast) begin
              state   <= ST_IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
            end else begin
              cur_addr <= launch_addr;
              beat_q   <= launch_beat;
              rdata    <= launch_data;
              rresp    <= launch_resp;
              rlast    <= launch_last;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Self-checking bench for axi_read_slave against a behavioural burst model.
module tb_axi_read_slave;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int MEM_WORDS = 256;
  localparam int IDX_W     = 8;

  logic              aclk;
  logic              areset;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  axi_read_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] tb_mem [MEM_WORDS];
  logic [DATA_W-1:0] exp_data [$];
  logic [1:0]        exp_resp [$];
  logic [ID_W-1:0]   exp_id;

  // AR fields to present once the current AR has been accepted (back-to-back)
  logic [ID_W-1:0]   nxt_id;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        nxt_len;
  logic [2:0]        nxt_size;
  logic [1:0]        nxt_burst;

  task automatic write_mem(input int unsigned w, input logic [DATA_W-1:0] d);
    mem_we    = 1'b1;
    mem_waddr = IDX_W'(w);
    mem_wdata = d;
    @(negedge aclk);
    mem_we    = 1'b0;
    tb_mem[w] = d;
  endtask

  task automatic model_burst(input logic [ID_W-1:0] id, input longint unsigned addr,
                             input int unsigned len, input int unsigned size,
                             input int unsigned burst);
    longint unsigned nb, wb, base, a, w;
    bit slverr;
    exp_data.delete();
    exp_resp.delete();
    exp_id = id;
    nb = 64'd1 << size;
    slverr = (nb > DATA_W / 8) || (burst == 3) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
             (burst == 2 && (addr % nb) != 0);
    for (int unsigned i = 0; i <= len; i++) begin
      if (burst == 1) begin
        a = (i == 0) ? addr : (addr / nb) * nb + i * nb;
      end else if (burst == 2) begin
        wb   = (len + 1) * nb;
        base = (addr / wb) * wb;
        a    = base + (addr - base + i * nb) % wb;
      end else begin
        a = addr;
      end
      w = a / (DATA_W / 8);
      if (slverr) begin
        exp_data.push_back('0); exp_resp.push_back(2'd2);
      end else if (w >= MEM_WORDS) begin
        exp_data.push_back('0); exp_resp.push_back(2'd3);
      end else begin
        exp_data.push_back(tb_mem[int'(w)]); exp_resp.push_back(2'd0);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge just before the AR handshake edge.
  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    while (arready !== 1'b1 && t < 50) begin
      @(negedge aclk);
      t++;
    end
    n_checks++;
    if (arready !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_accept: arready=%b required 1 within 50 cycles", arready);
    end
  endtask

  // mode 0: rready always 1; mode 1: 1,0,0,1 repeating; mode 2: random
  task automatic collect(input bit keep_ar, input int mode, input string tag);
    int idx = 0;
    int cyc = 0;
    bit rr;
    @(negedge aclk);
    if (keep_ar) begin
      arid = nxt_id; araddr = nxt_addr; arlen = nxt_len; arsize = nxt_size; arburst = nxt_burst;
    end else begin
      arvalid = 1'b0;
    end
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: rvalid=%b required 1 one cycle after AR handshake", tag, rvalid);
    end
    while (idx < exp_data.size() && cyc < 300) begin
      n_checks++;
      if (rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s rvalid beat %0d: got %b required 1", tag, idx, rvalid);
      end else begin
        n_checks++;
        if (rid !== exp_id) begin
          n_fail++; $display("FAIL %s rid beat %0d: got %h required %h", tag, idx, rid, exp_id);
        end
        n_checks++;
        if (rdata !== exp_data[idx]) begin
          n_fail++; $display("FAIL %s rdata beat %0d: got %h required %h", tag, idx, rdata, exp_data[idx]);
        end
        n_checks++;
        if (rresp !== exp_resp[idx]) begin
          n_fail++; $display("FAIL %s rresp beat %0d: got %0d required %0d", tag, idx, rresp, exp_resp[idx]);
        end
        n_checks++;
        if (rlast !== (idx == exp_data.size() - 1)) begin
          n_fail++; $display("FAIL %s rlast beat %0d: got %b required %b", tag, idx, rlast, idx == exp_data.size() - 1);
        end
        n_checks++;
        if (arready !== 1'b0) begin
          n_fail++; $display("FAIL %s arready during burst: got %b required 0", tag, arready);
        end
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      rready = rr;
      if (rvalid === 1'b1 && rr) idx++;
      cyc++;
      @(negedge aclk);
    end
    rready = 1'b0;
    n_checks++;
    if (idx != exp_data.size()) begin
      n_fail++; $display("FAIL %s beat_count: got %0d required %0d", tag, idx, exp_data.size());
    end
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++; $display("FAIL %s rvalid after rlast: got %b required 0", tag, rvalid);
    end
    n_checks++;
    if (arready !== 1'b1) begin
      n_fail++; $display("FAIL %s arready after rlast: got %b required 1", tag, arready);
    end
  endtask

  task automatic run(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input int mode, input string tag);
    model_burst(id, addr, len, size, burst);
    send_ar(id, addr, len, size, burst);
    collect(1'b0, mode, tag);
  endtask

  task automatic test_reset();
    areset = 1'b1; arvalid = 1'b0; rready = 1'b0; mem_we = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    mem_waddr = '0; mem_wdata = '0;
    @(negedge aclk);
    // memory is loaded while still in reset; writes must land regardless
    for (int unsigned w = 0; w < MEM_WORDS; w++) write_mem(w, $urandom);
    n_checks++; if (arready !== 1'b0) begin n_fail++; $display("FAIL reset arready: got %b required 0", arready); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset rvalid: got %b required 0", rvalid); end
    n_checks++; if (rlast !== 1'b0) begin n_fail++; $display("FAIL reset rlast: got %b required 0", rlast); end
    n_checks++; if (rresp !== 2'd0) begin n_fail++; $display("FAIL reset rresp: got %0d required 0", rresp); end
    n_checks++; if (rid !== '0) begin n_fail++; $display("FAIL reset rid: got %h required 0", rid); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset rdata: got %h required 0", rdata); end
    areset = 1'b0;
    @(negedge aclk);
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL release arready: got %b required 1", arready); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL release rvalid: got %b required 0", rvalid); end
  endtask

  task automatic test_incr();
    for (int unsigned i = 0; i < 4; i++) write_mem(i, 32'hA0 + i);
    run(4'h5, 32'h0, 8'd3, 3'd2, 2'd1, 0, "incr");
  endtask

  task automatic test_wrap();
    run(4'h6, 32'h8, 8'd3, 3'd2, 2'd2, 0, "wrap");
    run(4'h7, 32'h34, 8'd7, 3'd2, 2'd2, 0, "wrap8");
  endtask

  task automatic test_backpressure();
    run(4'h8, 32'h20, 8'd3, 3'd2, 2'd1, 1, "backpressure");
  endtask

  task automatic test_errors();
    logic [ADDR_W-1:0] a [8] = '{32'h0, 32'h400, 32'h0, 32'h4, 32'h6, 32'h3F8, 32'h10, 32'h3};
    logic [7:0]        l [8] = '{8'd3, 8'd1, 8'd3, 8'd2, 8'd3, 8'd3, 8'd2, 8'd2};
    logic [2:0]        s [8] = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd2};
    logic [1:0]        b [8] = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 8; i++) run(ID_W'(i), a[i], l[i], s[i], b[i], 0, $sformatf("err%0d", i));
  endtask

  task automatic test_mem_precedence();
    write_mem(10, 32'h1111_0000);
    write_mem(11, 32'h2222_0000);
    model_burst(4'h9, 40, 1, 2, 1);
    send_ar(4'h9, 32'd40, 8'd1, 3'd2, 2'd1);
    mem_we = 1'b1; mem_waddr = 8'd10; mem_wdata = 32'h3333_0000;
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b0; mem_wdata = 32'h4444_0000;
    @(negedge aclk);
    mem_we = 1'b0; tb_mem[10] = 32'h4444_0000;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_data[0]) begin
      n_fail++; $display("FAIL prec beat0: rvalid=%b rdata=%h required 1 / %h", rvalid, rdata, exp_data[0]);
    end
    rready = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (rdata !== exp_data[1] || rlast !== 1'b1) begin
      n_fail++; $display("FAIL prec beat1: rdata=%h rlast=%b required %h / 1", rdata, rlast, exp_data[1]);
    end
    @(negedge aclk);
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL prec end rvalid: got %b required 0", rvalid); end
    run(4'hA, 32'd40, 8'd0, 3'd2, 2'd1, 0, "prec_reread");
  endtask

  task automatic test_reset_mid_burst();
    model_burst(4'hB, 32'h40, 7, 2, 1);
    send_ar(4'hB, 32'h40, 8'd7, 3'd2, 2'd1);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data[i]) begin
        n_fail++; $display("FAIL midrst beat%0d: rvalid=%b rdata=%h required 1 / %h", i, rvalid, rdata, exp_data[i]);
      end
      if (i == 2) begin areset = 1'b1; rready = 1'b0; end
      @(negedge aclk);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b0) begin
        n_fail++; $display("FAIL midrst in reset: rvalid=%b arready=%b required 0 / 0", rvalid, arready);
      end
      @(negedge aclk);
    end
    areset = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midrst release: arready=%b rvalid=%b required 1 / 0", arready, rvalid);
    end
    run(4'hC, 32'h80, 8'd3, 3'd2, 2'd1, 2, "after_reset");
  endtask

  task automatic test_back_to_back();
    model_burst(4'hD, 32'h100, 3, 2, 1);
    nxt_id = 4'hE; nxt_addr = 32'h200; nxt_len = 8'd5; nxt_size = 3'd2; nxt_burst = 2'd1;
    send_ar(4'hD, 32'h100, 8'd3, 3'd2, 2'd1);
    collect(1'b1, 0, "b2b_first");
    model_burst(4'hE, 32'h200, 5, 2, 1);
    collect(1'b0, 0, "b2b_second");
  endtask

  task automatic test_random();
    int unsigned size, burst, len, addr;
    for (int n = 0; n < 30; n++) begin
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2 && $urandom_range(0, 4) != 0) begin
        len = (1 << $urandom_range(1, 4)) - 1;
      end else begin
        len = $urandom_range(0, 15);
      end
      addr = $urandom_range(0, 1100);
      if (burst == 2 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 1);
      if ($urandom_range(0, 2) == 0) write_mem($urandom_range(0, MEM_WORDS - 1), $urandom);
      run(ID_W'($urandom), addr, 8'(len), 3'(size), 2'(burst), 2, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_mem_precedence();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, R data width (32 or 64).
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL have parameter MEM_WORDS, default 256, internal memory depth in DATA_W words.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with these ports:
- aclk  in  1  sole clock; all logic on its rising edge.
- areset  in  1  synchronous, active-high reset.
- arid  in  ID_W  read ID.
- araddr  in  ADDR_W  start byte address.
- arlen  in  8  beats minus 1.
- arsize  in  3  log2 of bytes per beat.
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- arvalid / arready  in / out  1  AR handshake.
- rid  out  ID_W  echoed arid.
- rdata  out  DATA_W  read data.
- rresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR.
- rlast  out  1  final beat.
- rvalid / rready  out / in  1  R handshake.
- mem_we  in  1  backdoor write enable.
- mem_waddr  in  $clog2(MEM_WORDS)  backdoor word address.
- mem_wdata  in  DATA_W  backdoor write data.

Function
REQ-006 SHALL implement FSM states IDLE and BURST.
- IDLE: arready=1, rvalid=0.
- BURST: arready=0.
REQ-007 SHALL, on arvalid&&arready in cycle N, capture the AR fields, enter BURST, and present beat 0 with rvalid=1 in cycle N+1.
REQ-008 SHALL advance one beat per cycle where rvalid&&rready, so full throughput is one beat per cycle.
REQ-009 SHALL hold rid, rdata, rresp and rlast stable while rvalid&&!rready.
REQ-010 SHALL assert rlast only on beat index arlen.
REQ-011 SHALL, on the rlast handshake, return to IDLE with rvalid=0 in the next cycle; arready=1 from that cycle. No AR acceptance in the same cycle as the last beat.
REQ-012 SHALL compute beat addresses as follows:
- FIXED: every beat at the start address.
- INCR: address plus 2^arsize per beat, aligned down to the size after the first beat.
- WRAP: wrap at a boundary of (arlen+1)*2^arsize bytes.
REQ-013 SHALL read rdata from word (addr / (DATA_W/8)) mod MEM_WORDS, captured in the register when the beat is launched.
REQ-014 SHALL return rresp=DECERR and rdata=0 for any beat whose word address is >= MEM_WORDS.
REQ-015 SHALL return rresp=SLVERR and rdata=0 on all arlen+1 beats if any of these hold:
- 2^arsize > DATA_W/8;
- arburst=3;
- WRAP with arlen not in {1,3,7,15};
- WRAP with araddr not aligned to 2^arsize.
REQ-016 SHALL apply mem_we writes on the clock edge, with these precedence rules:
- A beat launched in the same cycle as a write to its address returns the old data.
- Beats already presented are unaffected.
REQ-017 SHALL return rresp=OKAY otherwise. Error priority: SLVERR over DECERR.

Reset
REQ-018 SHALL, while areset=1 at a clock edge, force the outputs to these values next cycle:
- FSM=IDLE, arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0.
REQ-019 SHALL assert arready=1 in the first cycle after areset is deasserted.
REQ-020 SHALL abandon any burst in progress on reset, with no further beats of it issued.
REQ-021 SHALL NOT clear memory contents on reset; backdoor writes SHALL remain honoured during reset.

Structure
REQ-022 SHALL take burst and response encodings (axi_burst_e, axi_resp_e) and the FSM state typedef from a shared package axi_pkg.
REQ-023 SHALL place next-beat address calculation in one sub-module, axi_addr_gen, purely combinational: (addr, size, len, burst) -> next addr.
REQ-024 SHALL hold memory in a register array; no vendor RAM macro.

Verification
REQ-025 INCR: preload words 0..3 = 0xA0..0xA3; AR araddr=0x0, arlen=3, arsize=2, rready=1. Expect rvalid in the cycle after the AR handshake, rdata A0,A1,A2,A3 on consecutive cycles, rlast on the 4th beat, rresp=OKAY, rid=arid.
REQ-026 WRAP: AR araddr=0x8, arlen=3, arsize=2, burst=WRAP. Expect words 2,3,0,1.
REQ-027 Backpressure: INCR burst with rready toggling 1,0,0,1. Expect R outputs held stable during stalls and 4 beats total.
REQ-028 Errors:
- arsize=3 with DATA_W=32 -> all beats SLVERR, rdata=0.
- araddr=4*MEM_WORDS -> DECERR.
- arburst=3 -> SLVERR.
REQ-029 Reset mid-burst: assert areset after beat 1 of an 8-beat burst. Expect rvalid=0 next cycle, arready=1 in the first cycle after release, and a new AR served correctly.
REQ-030 Back-to-back: a second arvalid held high during the first burst. Expect it accepted the cycle after the first rlast handshake and no beats lost or merged.
